// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: instruction class
// codes, the per-edge update selector and a small decode helper.
package id_ex_stage_pkg;

    // Instruction classes seen by the ID/EX register. NOP is the bubble code.
    typedef enum logic [2:0] {
        INS_ID_NOP   = 3'd0,
        INS_ID_RTYPE = 3'd1,
        INS_ID_LW    = 3'd2,
        INS_ID_SW    = 3'd3,
        INS_ID_BEQ   = 3'd4,
        INS_ID_J     = 3'd5
    } ins_id_e;

    // What the EX register bank does on the next rising edge.
    typedef enum logic [1:0] {
        EX_BUBBLE  = 2'd0,
        EX_KEEP    = 2'd1,
        EX_CAPTURE = 2'd2
    } ex_upd_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         INS_W    = 3;
    localparam int         REG_W    = 5;
    localparam int         ALU_W    = 4;

    // True when the instruction class produces its result only after MEM.
    function automatic logic is_load(input logic [INS_W-1:0] ins);
        return ins == INS_ID_LW;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side and EX-side field bundle of the ID/EX register. The ID stage is
// the master (drives id_*, observes ex_*); the register is the slave.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                     id_valid;
    logic [INS_W-1:0]         id_ins_id;
    logic [REG_W-1:0]         id_rs;
    logic [REG_W-1:0]         id_rt;
    logic [REG_W-1:0]         id_rd;
    logic                     id_uses_rs;
    logic                     id_uses_rt;
    logic signed [DATA_W-1:0] id_rs_data;
    logic signed [DATA_W-1:0] id_rt_data;
    logic signed [DATA_W-1:0] id_imm;
    logic [ALU_W-1:0]         id_alu_op;

    logic                     ex_valid;
    logic [INS_W-1:0]         ex_ins_id;
    logic [REG_W-1:0]         ex_rs;
    logic [REG_W-1:0]         ex_rt;
    logic [REG_W-1:0]         ex_rd;
    logic signed [DATA_W-1:0] ex_rs_data;
    logic signed [DATA_W-1:0] ex_rt_data;
    logic signed [DATA_W-1:0] ex_imm;
    logic [ALU_W-1:0]         ex_alu_op;

    modport master (
        output id_valid, id_ins_id, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_alu_op,
        input  ex_valid, ex_ins_id, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
               ex_imm, ex_alu_op
    );

    modport slave (
        input  id_valid, id_ins_id, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_alu_op,
        output ex_valid, ex_ins_id, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
               ex_imm, ex_alu_op
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that
// reads the destination of a load still sitting in EX. A load to $0 never
// hazards, and a source field the decoder marks unused is ignored.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid,
    input  logic [INS_W-1:0] ex_ins_id,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             load_use
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_uses_rs & (id_rs == ex_rd);
    assign rt_hit   = id_uses_rt & (id_rt == ex_rd);
    assign load_use = ex_valid & is_load(ex_ins_id) & (ex_rd != REG_ZERO)
                    & id_valid & (rs_hit | rt_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion. Update priority
// on each edge: flush, hold, load-use bubble, capture, idle bubble. A bubble
// clears the control fields only; data fields keep stale values since
// ex_valid=0 and ex_rd=0 make downstream ignore them.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    input  logic             flush_ex,
    input  logic             hold,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] lu_stall_cnt
);
    // Saturating increment: the bubble counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                     load_use;
    ex_upd_e                  upd;
    logic                     cnt_inc;
    logic signed [DATA_W-1:0] cap_rs_data;
    logic signed [DATA_W-1:0] cap_rt_data;
    logic signed [DATA_W-1:0] cap_imm;

    assign cap_rs_data = bus.id_rs_data;
    assign cap_rt_data = bus.id_rt_data;
    assign cap_imm     = bus.id_imm;

    load_use_detect u_lud (
        .ex_valid   (bus.ex_valid),
        .ex_ins_id  (bus.ex_ins_id),
        .ex_rd      (bus.ex_rd),
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rs (bus.id_uses_rs),
        .id_uses_rt (bus.id_uses_rt),
        .load_use   (load_use)
    );

    // A flush squashes the hazard, so upstream must not freeze in that case.
    assign stall_if_id = load_use & ~flush_ex;

    // Select the register-bank action; only an actually inserted load-use
    // bubble advances the counter.
    always_comb begin
        upd     = EX_BUBBLE;
        cnt_inc = 1'b0;
        if (flush_ex) begin
            upd = EX_BUBBLE;
        end else if (hold) begin
            upd = EX_KEEP;
        end else if (load_use) begin
            upd     = EX_BUBBLE;
            cnt_inc = 1'b1;
        end else if (bus.id_valid) begin
            upd = EX_CAPTURE;
        end
    end

    // Control fields: cleared on a bubble, copied on capture, kept on hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_ins_id <= INS_ID_NOP;
            bus.ex_rs     <= REG_ZERO;
            bus.ex_rt     <= REG_ZERO;
            bus.ex_rd     <= REG_ZERO;
            bus.ex_alu_op <= '0;
        end else begin
            case (upd)
                EX_BUBBLE: begin
                    bus.ex_valid  <= 1'b0;
                    bus.ex_ins_id <= INS_ID_NOP;
                    bus.ex_rs     <= REG_ZERO;
                    bus.ex_rt     <= REG_ZERO;
                    bus.ex_rd     <= REG_ZERO;
                    bus.ex_alu_op <= '0;
                end
                EX_CAPTURE: begin
                    bus.ex_valid  <= 1'b1;
                    bus.ex_ins_id <= bus.id_ins_id;
                    bus.ex_rs     <= bus.id_rs;
                    bus.ex_rt     <= bus.id_rt;
                    bus.ex_rd     <= bus.id_rd;
                    bus.ex_alu_op <= bus.id_alu_op;
                end
                default: ;
            endcase
        end
    end

    // Data fields only load on capture; bubbles leave them stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_rs_data <= '0;
            bus.ex_rt_data <= '0;
            bus.ex_imm     <= '0;
        end else if (upd == EX_CAPTURE) begin
            bus.ex_rs_data <= cap_rs_data;
            bus.ex_rt_data <= cap_rt_data;
            bus.ex_imm     <= cap_imm;
        end
    end

    // Count inserted load-use bubbles, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= '0;
        end else if (cnt_inc) begin
            lu_stall_cnt <= sat_inc(lu_stall_cnt);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, a behavioural
// model compared every cycle, plus literal expectations at key points.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_ex;
    logic          hold;
    logic          stall_if_id;
    logic [CW-1:0] lu_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_if #(.DATA_W(DW)) bus ();

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush_ex     (flush_ex),
        .hold         (hold),
        .stall_if_id  (stall_if_id),
        .lu_stall_cnt (lu_stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what EX must hold according to the rules.
    logic          m_valid;
    logic [2:0]    m_ins;
    logic [4:0]    m_rs, m_rt, m_rd;
    logic [3:0]    m_alu;
    logic [DW-1:0] m_rs_data, m_rt_data, m_imm;
    int            m_cnt;

    function automatic logic model_hazard();
        logic reads;
        reads = (bus.id_uses_rs && bus.id_rs == m_rd) || (bus.id_uses_rt && bus.id_rt == m_rd);
        return m_valid && (m_ins == INS_ID_LW) && (m_rd != 0) && bus.id_valid && reads;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_ins <= INS_ID_NOP; m_rs <= 0; m_rt <= 0; m_rd <= 0; m_alu <= 0;
            m_rs_data <= 0; m_rt_data <= 0; m_imm <= 0; m_cnt <= 0;
        end else if (!flush_ex && hold) begin
            m_cnt <= m_cnt;
        end else if (!flush_ex && !model_hazard() && bus.id_valid) begin
            m_valid <= 1; m_ins <= bus.id_ins_id; m_rs <= bus.id_rs; m_rt <= bus.id_rt;
            m_rd <= bus.id_rd; m_alu <= bus.id_alu_op; m_rs_data <= bus.id_rs_data;
            m_rt_data <= bus.id_rt_data; m_imm <= bus.id_imm;
        end else begin
            m_valid <= 0; m_ins <= INS_ID_NOP; m_rs <= 0; m_rt <= 0; m_rd <= 0; m_alu <= 0;
            if (!flush_ex && model_hazard()) m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        check("m_ex_ins_id", 64'(bus.ex_ins_id), 64'(m_ins));
        check("m_ex_rs", 64'(bus.ex_rs), 64'(m_rs));
        check("m_ex_rt", 64'(bus.ex_rt), 64'(m_rt));
        check("m_ex_rd", 64'(bus.ex_rd), 64'(m_rd));
        check("m_ex_alu_op", 64'(bus.ex_alu_op), 64'(m_alu));
        check("m_lu_stall_cnt", 64'(lu_stall_cnt), 64'(m_cnt));
        check("m_stall_if_id", 64'(stall_if_id), 64'(model_hazard() && !flush_ex));
        if (m_valid) begin
            check("m_ex_rs_data", 64'(bus.ex_rs_data), 64'(m_rs_data));
            check("m_ex_rt_data", 64'(bus.ex_rt_data), 64'(m_rt_data));
            check("m_ex_imm", 64'(bus.ex_imm), 64'(m_imm));
        end
    end

    task automatic set_id(input logic v, input logic [2:0] ins, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                          input logic urt, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                          input logic [DW-1:0] imm, input logic [3:0] alu);
        bus.id_valid = v; bus.id_ins_id = ins; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_uses_rs = urs; bus.id_uses_rt = urt; bus.id_rs_data = rsd;
        bus.id_rt_data = rtd; bus.id_imm = imm; bus.id_alu_op = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush_ex = 0; hold = 0;
        set_id(1'b1, INS_ID_LW, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
               $urandom, $urandom, $urandom, 4'($urandom));
        repeat (3) tick();
        check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_ex_ins_id", 64'(bus.ex_ins_id), 64'(INS_ID_NOP));
        check("rst_ex_rd", 64'(bus.ex_rd), 64'd0);
        check("rst_ex_rs_data", 64'(bus.ex_rs_data), 64'd0);
        check("rst_stall", 64'(stall_if_id), 64'd0);
        check("rst_cnt", 64'(lu_stall_cnt), 64'd0);
        set_id(0, INS_ID_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;

        // Pass-through of an R-type.
        set_id(1, INS_ID_RTYPE, 1, 2, 3, 1, 1, 32'h11, 32'h22, 32'h0, 4'h2);
        tick();
        check("pt_ex_rs", 64'(bus.ex_rs), 64'd1);
        check("pt_ex_rt", 64'(bus.ex_rt), 64'd2);
        check("pt_ex_rd", 64'(bus.ex_rd), 64'd3);
        check("pt_ex_rs_data", 64'(bus.ex_rs_data), 64'h11);
        check("pt_ex_rt_data", 64'(bus.ex_rt_data), 64'h22);
        check("pt_ex_valid", 64'(bus.ex_valid), 64'd1);

        // Load-use: lw $5 then add reading $5.
        set_id(1, INS_ID_LW, 1, 5, 5, 1, 0, 32'h100, 0, 32'h4, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 5, 6, 7, 1, 1, 32'h55, 32'h66, 0, 4'h3);
        settle();
        check("lu_stall", 64'(stall_if_id), 64'd1);
        tick();
        check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        check("lu_bubble_ins", 64'(bus.ex_ins_id), 64'(INS_ID_NOP));
        check("lu_bubble_rd", 64'(bus.ex_rd), 64'd0);
        check("lu_cnt", 64'(lu_stall_cnt), 64'd1);
        check("lu_stall_gone", 64'(stall_if_id), 64'd0);
        tick();
        check("lu_capture_valid", 64'(bus.ex_valid), 64'd1);
        check("lu_capture_rs", 64'(bus.ex_rs), 64'd5);
        check("lu_capture_rd", 64'(bus.ex_rd), 64'd7);

        // No false stall: lw $0, and unused rt.
        set_id(1, INS_ID_LW, 2, 0, 0, 1, 0, 0, 0, 0, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 0, 0, 9, 1, 1, 0, 0, 0, 4'h1);
        settle();
        check("nf_zero_stall", 64'(stall_if_id), 64'd0);
        tick();
        check("nf_zero_valid", 64'(bus.ex_valid), 64'd1);
        set_id(1, INS_ID_LW, 2, 5, 5, 1, 0, 0, 0, 0, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 9, 5, 10, 1, 0, 0, 0, 0, 4'h1);
        settle();
        check("nf_unused_stall", 64'(stall_if_id), 64'd0);
        tick();
        check("nf_unused_valid", 64'(bus.ex_valid), 64'd1);
        check("nf_cnt", 64'(lu_stall_cnt), 64'd1);

        // Flush beats load-use.
        set_id(1, INS_ID_LW, 2, 5, 5, 1, 0, 0, 0, 0, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 5, 1, 12, 1, 1, 0, 0, 0, 4'h1);
        flush_ex = 1;
        settle();
        check("fl_stall", 64'(stall_if_id), 64'd0);
        tick();
        flush_ex = 0;
        check("fl_valid", 64'(bus.ex_valid), 64'd0);
        check("fl_cnt", 64'(lu_stall_cnt), 64'd1);

        // Hold for three cycles keeps EX untouched.
        set_id(1, INS_ID_RTYPE, 3, 4, 8, 1, 1, 32'hAAA, 32'hBBB, 32'hCCC, 4'h5);
        tick();
        hold = 1;
        set_id(1, INS_ID_RTYPE, 13, 14, 15, 1, 1, 32'h1, 32'h2, 32'h3, 4'h6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hd_rd", 64'(bus.ex_rd), 64'd8);
            check("hd_rs_data", 64'(bus.ex_rs_data), 64'hAAA);
            check("hd_alu", 64'(bus.ex_alu_op), 64'h5);
        end
        hold = 0;

        // Hold with load-use: stall stays, counter frozen until release.
        set_id(1, INS_ID_LW, 2, 6, 6, 1, 0, 0, 0, 0, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 6, 1, 16, 1, 1, 0, 0, 0, 4'h1);
        hold = 1;
        settle();
        check("hl_stall", 64'(stall_if_id), 64'd1);
        tick();
        check("hl_kept_ins", 64'(bus.ex_ins_id), 64'(INS_ID_LW));
        check("hl_cnt", 64'(lu_stall_cnt), 64'd1);
        hold = 0;
        tick();
        check("hl_cnt_after", 64'(lu_stall_cnt), 64'd2);
        tick();

        // Saturation at 2'b11 over five more bubbles.
        for (int i = 0; i < 5; i++) begin
            set_id(1, INS_ID_LW, 1, 10, 10, 1, 0, 0, 0, 0, 4'h2);
            tick();
            set_id(1, INS_ID_RTYPE, 1, 10, 11, 0, 1, 0, 0, 0, 4'h1);
            tick();
        end
        check("sat_cnt", 64'(lu_stall_cnt), 64'd3);

        // Reset mid-stall drops the stall immediately.
        set_id(1, INS_ID_LW, 1, 11, 11, 1, 0, 0, 0, 0, 4'h2);
        tick();
        set_id(1, INS_ID_RTYPE, 11, 1, 12, 1, 1, 0, 0, 0, 4'h1);
        settle();
        check("mr_stall_before", 64'(stall_if_id), 64'd1);
        #1 rst_n = 0;
        #1;
        check("mr_stall", 64'(stall_if_id), 64'd0);
        check("mr_valid", 64'(bus.ex_valid), 64'd0);
        check("mr_cnt", 64'(lu_stall_cnt), 64'd0);
        tick();
        rst_n = 1;
        set_id(0, INS_ID_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
